// File: rtl/nts_api_stats_pkg.sv
// Shared constants for the NTS API statistics slave: register map, CTRL bit
// positions and the read-only identification words.
package nts_api_stats_pkg;

    localparam logic [7:0] ADDR_NAME0    = 8'h00;
    localparam logic [7:0] ADDR_NAME1    = 8'h01;
    localparam logic [7:0] ADDR_VERSION  = 8'h02;
    localparam logic [7:0] ADDR_CTRL     = 8'h08;
    localparam logic [7:0] ADDR_SCRATCH  = 8'h09;
    localparam logic [7:0] ADDR_SNAPSHOT = 8'h0a;
    localparam logic [7:0] ADDR_CNT_BASE = 8'h10;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;
    localparam int CTRL_SATCAP_BIT = 31;

    localparam logic [31:0] NAME0_VAL   = 32'h4e54532d;
    localparam logic [31:0] NAME1_VAL   = 32'h53544154;
    localparam logic [31:0] VERSION_VAL = 32'h302e3130;

endpackage

// File: rtl/nts_event_counter.sv
// One event counter with its snapshot register and optional clear-on-snapshot.
// NTS_API_STATS_SATURATE_EN selects saturation at all-ones instead of wrapping.
module nts_event_counter
    import nts_api_stats_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             ev,
    input  logic             snap_req,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] snap
);

    logic             inc;
    logic [WIDTH-1:0] bumped;

    assign inc = enable & ev;

`ifdef NTS_API_STATS_SATURATE_EN
    assign bumped = (&count) ? count : count + WIDTH'(1);
`else
    assign bumped = count + WIDTH'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            snap  <= '0;
        end else begin
            if (snap_req)
                snap <= count;
            // An event landing on the clearing snapshot opens the new epoch at 1.
            if (snap_req && clear)
                count <= inc ? WIDTH'(1) : '0;
            else if (inc)
                count <= bumped;
        end
    end

endmodule

// File: rtl/nts_api_stats_slave.sv
// API slave: one register access per chip-select rising edge, ID/CTRL/SCRATCH
// registers and snapshot-read event counters. Option: NTS_API_STATS_SATURATE_EN.
module nts_api_stats_slave
    import nts_api_stats_pkg::*;
#(
    parameter int NUM_COUNTERS  = 4,
    parameter int COUNTER_WIDTH = 64
) (
    input  logic                    i_clk,
    input  logic                    i_areset,
    input  logic                    i_cs,
    input  logic                    i_we,
    input  logic [7:0]              i_address,
    input  logic [31:0]             i_write_data,
    output logic [31:0]             o_read_data,
    input  logic [NUM_COUNTERS-1:0] i_events,
    output logic [31:0]             o_ctrl
);

`ifdef NTS_API_STATS_SATURATE_EN
    localparam logic [31:0] CTRL_FIXED = 32'(1) << CTRL_SATCAP_BIT;
`else
    localparam logic [31:0] CTRL_FIXED = 32'h0;
`endif

    logic        cs_d;
    logic        acc;
    logic        snap_req;
    logic [31:0] ctrl;
    logic [31:0] scratch;
    logic [31:0] rd_mux;
    logic [63:0] snap_ext;

    // Live counts are deliberately not readable; only snapshots reach the bus.
    logic [NUM_COUNTERS-1:0][COUNTER_WIDTH-1:0] live_unused;
    logic [NUM_COUNTERS-1:0][COUNTER_WIDTH-1:0] snaps;

    assign acc      = i_cs & ~cs_d;
    assign snap_req = acc & i_we & (i_address == ADDR_SNAPSHOT);
    assign o_ctrl   = ctrl;

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            cs_d        <= 1'b0;
            o_read_data <= '0;
            ctrl        <= CTRL_FIXED;
            scratch     <= '0;
        end else begin
            cs_d <= i_cs;
            if (acc && i_we) begin
                case (i_address)
                    ADDR_CTRL:    ctrl    <= i_write_data | CTRL_FIXED;
                    ADDR_SCRATCH: scratch <= i_write_data;
                    default: ;
                endcase
            end
            if (acc && !i_we)
                o_read_data <= rd_mux;
        end
    end

    always_comb begin
        rd_mux   = '0;
        snap_ext = '0;
        case (i_address)
            ADDR_NAME0:   rd_mux = NAME0_VAL;
            ADDR_NAME1:   rd_mux = NAME1_VAL;
            ADDR_VERSION: rd_mux = VERSION_VAL;
            ADDR_CTRL:    rd_mux = ctrl;
            ADDR_SCRATCH: rd_mux = scratch;
            default:      rd_mux = '0;
        endcase
        for (int k = 0; k < NUM_COUNTERS; k++) begin
            snap_ext = 64'(snaps[k]);
            if (i_address == ADDR_CNT_BASE + 8'(2 * k))
                rd_mux = snap_ext[63:32];
            if (i_address == ADDR_CNT_BASE + 8'(2 * k + 1))
                rd_mux = snap_ext[31:0];
        end
    end

    for (genvar k = 0; k < NUM_COUNTERS; k++) begin : g_cnt
        nts_event_counter #(
            .WIDTH(COUNTER_WIDTH)
        ) u_cnt (
            .clk     (i_clk),
            .rst     (i_areset),
            .enable  (ctrl[CTRL_ENABLE_BIT]),
            .ev      (i_events[k]),
            .snap_req(snap_req),
            .clear   (ctrl[CTRL_CLEAR_BIT]),
            .count   (live_unused[k]),
            .snap    (snaps[k])
        );
    end

endmodule

// File: tb/tb_nts_api_stats_slave.sv
// Self-checking bench for nts_api_stats_slave: table of register accesses plus
// hand sequences for held chip select, counting, clear-on-snapshot, wrap, reset.
module tb_nts_api_stats_slave;

`ifdef NTS_API_STATS_SATURATE_EN
    localparam logic [31:0] FIX       = 32'h8000_0000;
    localparam logic [3:0]  SMALL_TOP = 4'hf;
`else
    localparam logic [31:0] FIX       = 32'h0;
    localparam logic [3:0]  SMALL_TOP = 4'h0;
`endif

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [3:0]  events = '0;
    logic [31:0] ctrl;

    logic        s_ev = 1'b0;
    logic        s_snap = 1'b0;
    logic [3:0]  s_count;
    logic [3:0]  s_snapv;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    nts_api_stats_slave #(
        .NUM_COUNTERS (4),
        .COUNTER_WIDTH(33)
    ) dut (
        .i_clk       (clk),
        .i_areset    (areset),
        .i_cs        (cs),
        .i_we        (we),
        .i_address   (addr),
        .i_write_data(wdata),
        .o_read_data (rdata),
        .i_events    (events),
        .o_ctrl      (ctrl)
    );

    // Narrow standalone counter so wrap/saturate is reachable in a few cycles.
    nts_event_counter #(
        .WIDTH(4)
    ) u_small (
        .clk     (clk),
        .rst     (areset),
        .enable  (1'b1),
        .ev      (s_ev),
        .snap_req(s_snap),
        .clear   (1'b0),
        .count   (s_count),
        .snap    (s_snapv)
    );

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic access(input logic w, input logic [7:0] a, input logic [31:0] d,
                          input int hold, input logic [3:0] ev);
        @(negedge clk);
        cs = 1'b1; we = w; addr = a; wdata = d; events = ev;
        @(negedge clk);
        events = '0;
        repeat (hold - 1) @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] exp, input string nm);
        access(1'b0, a, 32'h0, 1, 4'h0);
        exp_q.push_back(exp);
        @(negedge clk);
        chk(nm, rdata, exp_q.pop_front());
    endtask

    task automatic pulse(input logic [3:0] mask, input int n);
        repeat (n) begin
            @(negedge clk); events = mask;
            @(negedge clk); events = '0;
        end
    endtask

    initial begin
        vecs.push_back('{0, 8'h00, 32'h0,        32'h4e54532d, "name0"});
        vecs.push_back('{0, 8'h01, 32'h0,        32'h53544154, "name1"});
        vecs.push_back('{0, 8'h02, 32'h0,        32'h302e3130, "version"});
        vecs.push_back('{1, 8'h09, 32'h12345678, 32'h302e3130, "wr_scratch_hold"});
        vecs.push_back('{0, 8'h09, 32'h0,        32'h12345678, "scratch"});
        vecs.push_back('{1, 8'h00, 32'hffffffff, 32'h12345678, "wr_ro_hold"});
        vecs.push_back('{0, 8'h00, 32'h0,        32'h4e54532d, "name0_after_wr"});
        vecs.push_back('{1, 8'h08, 32'h25a55a5c, 32'h4e54532d, "wr_ctrl_hold"});
        vecs.push_back('{0, 8'h08, 32'h0,        32'h25a55a5c | FIX, "ctrl"});
        vecs.push_back('{0, 8'h0a, 32'h0,        32'h0,        "snapshot_rd"});
        vecs.push_back('{0, 8'h09, 32'h0,        32'h12345678, "scratch2"});
        vecs.push_back('{0, 8'h03, 32'h0,        32'h0,        "unmapped03"});
        vecs.push_back('{0, 8'h09, 32'h0,        32'h12345678, "scratch3"});
        vecs.push_back('{0, 8'hff, 32'h0,        32'h0,        "unmappedff"});
        vecs.push_back('{0, 8'h02, 32'h0,        32'h302e3130, "version2"});
        vecs.push_back('{0, 8'h18, 32'h0,        32'h0,        "cnt_k4"});
        vecs.push_back('{0, 8'h02, 32'h0,        32'h302e3130, "version3"});
        vecs.push_back('{0, 8'h11, 32'h0,        32'h0,        "snap0_reset"});
        vecs.push_back('{1, 8'h08, 32'h0,        32'h0,        "wr_ctrl0_hold"});
        vecs.push_back('{0, 8'h08, 32'h0,        FIX,          "ctrl0"});

        repeat (2) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_ctrl", ctrl, FIX);

        foreach (vecs[i]) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1, 4'h0);
            exp_q.push_back(vecs[i].exp);
            @(negedge clk);
            chk(vecs[i].name, rdata, exp_q.pop_front());
        end

        // Held write: only the first data word may land.
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = 8'h09; wdata = 32'hdeadbeef;
        repeat (25) @(negedge clk);
        wdata = 32'h11111111;
        repeat (25) @(negedge clk);
        cs = 1'b0; we = 1'b0;
        do_read(8'h09, 32'hdeadbeef, "single_access");

        // Counting.
        access(1'b1, 8'h08, 32'h1, 1, 4'h0);
        pulse(4'b0100, 5);
        access(1'b1, 8'h0a, 32'h0, 1, 4'h0);
        do_read(8'h15, 32'd5, "cnt2_lsb");
        do_read(8'h14, 32'd0, "cnt2_msb");
        do_read(8'h11, 32'd0, "cnt0_lsb");
        do_read(8'h13, 32'd0, "cnt1_lsb");
        do_read(8'h17, 32'd0, "cnt3_lsb");

        // Clear on snapshot with an event on the snapshot cycle.
        access(1'b1, 8'h08, 32'h3, 1, 4'h0);
        access(1'b1, 8'h0a, 32'h0, 1, 4'h0);
        pulse(4'b0001, 7);
        access(1'b1, 8'h0a, 32'h0, 1, 4'b0001);
        do_read(8'h11, 32'd7, "clr_snap0");
        do_read(8'h15, 32'd0, "clr_snap2");
        access(1'b1, 8'h0a, 32'h0, 1, 4'h0);
        do_read(8'h11, 32'd1, "clr_carry");

        // Enable changes take effect on the cycle after the CTRL write.
        access(1'b1, 8'h08, 32'h0, 1, 4'b0010);
        pulse(4'b0010, 3);
        access(1'b1, 8'h08, 32'h1, 1, 4'b0010);
        access(1'b1, 8'h0a, 32'h0, 1, 4'h0);
        do_read(8'h13, 32'd1, "en_timing");
        do_read(8'h11, 32'd0, "cnt0_after_clr");
        chk("o_ctrl", ctrl, 32'h1 | FIX);

        // Wrap / saturate on the narrow counter.
        @(negedge clk); s_ev = 1'b1;
        repeat (15) @(negedge clk);
        s_ev = 1'b0; s_snap = 1'b1;
        @(negedge clk); s_snap = 1'b0;
        chk("small_full", s_snapv, 4'hf);
        s_ev = 1'b1;
        @(negedge clk); s_ev = 1'b0; s_snap = 1'b1;
        @(negedge clk); s_snap = 1'b0;
        chk("small_wrap", s_snapv, SMALL_TOP);
        chk("small_live", s_count, SMALL_TOP);

        // Reset in the middle of a held CTRL write.
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = 8'h08; wdata = 32'h0000_00f0;
        repeat (3) @(negedge clk);
        areset = 1'b1; wdata = 32'h0000_0055;
        @(negedge clk);
        chk("rst_hold_rdata", rdata, 32'h0);
        areset = 1'b0;
        repeat (5) @(negedge clk);
        wdata = 32'h0000_0066;
        repeat (5) @(negedge clk);
        cs = 1'b0; we = 1'b0;
        chk("rst_hold_ctrl_out", ctrl, 32'h55 | FIX);
        do_read(8'h08, 32'h55 | FIX, "rst_hold_ctrl");
        do_read(8'h13, 32'd0, "rst_snap1");
        do_read(8'h09, 32'd0, "rst_scratch");
        access(1'b1, 8'h0a, 32'h0, 1, 4'h0);
        do_read(8'h11, 32'd0, "rst_cnt0");
        do_read(8'h13, 32'd0, "rst_cnt1");
        do_read(8'h15, 32'd0, "rst_cnt2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nts_api_stats_slave.md
Name: nts_api_stats_slave

Overview:
API slave sitting directly downstream of the SPI-to-API decoder, on one of its o_api_cs lines. It converts the decoder's level-held chip select into exactly one register access per transaction. It exposes ID, control and scratch registers plus a bank of 64-bit event counters, read coherently through a snapshot. Its read data feeds back into the decoder's read-data bus slot for that slave.

Parameters:
NUM_COUNTERS, 4, number of event counters (1..8)
COUNTER_WIDTH, 64, counter width in bits (33..64); the MSB word is zero-extended

Ports:
i_clk  in  1  system clock
i_areset  in  1  reset, asynchronous, active-high
i_cs  in  1  chip select from decoder; level, held high for a whole transaction
i_we  in  1  write enable, valid while i_cs high
i_address  in  8  register word address
i_write_data  in  32  write data
o_read_data  out  32  registered read data, stable between accesses
i_events  in  NUM_COUNTERS  per-counter single-cycle event pulses
o_ctrl  out  32  CTRL register contents, for use elsewhere in the design

Behaviour:
- Reset (async, active-high): o_read_data=0, CTRL=0, SCRATCH=0, all counters=0, all snapshots=0, cs_d=0.
- Access strobe: acc = i_cs & ~cs_d, where cs_d is i_cs registered.
  - Exactly one access per i_cs rising edge, however long i_cs stays high.
  - i_cs held high performs no further access.
  - i_cs low→high again is a new access.
- Write: on acc with i_we=1, commit to the addressed register in the same cycle. o_read_data is unchanged.
- Read: on acc with i_we=0, o_read_data <= addressed value at the next edge. o_read_data is 2 cycles after i_cs rises and holds until the next read strobe.
- Address map:
  - 0x00 NAME0 = 0x4e54532d (RO)
  - 0x01 NAME1 = 0x53544154 (RO)
  - 0x02 VERSION = 0x302e3130 (RO)
  - 0x08 CTRL (RW): bit0 count_enable, bit1 clear_on_snapshot; other bits stored and read back
  - 0x09 SCRATCH (RW)
  - 0x0A SNAPSHOT (WO): any write triggers a snapshot; reads return 0
  - 0x10+2k: snapshot k MSB word, bits [COUNTER_WIDTH-1:32], zero-extended (RO)
  - 0x11+2k: snapshot k LSB word (RO)
  - Unmapped addresses and k>=NUM_COUNTERS: reads return 0.
  - Writes to RO or unmapped addresses are ignored.
- Counters:
  - When count_enable=1, counter k increments by 1 in each cycle where i_events[k]=1.
  - When count_enable=0, events are ignored.
  - Counters wrap from all-ones to 0.
- Snapshot (the write cycle of SNAPSHOT):
  - All snapshot registers are loaded with the pre-increment counter values, atomically.
  - If clear_on_snapshot=1, counters reload to 0, or to 1 if that counter's event is present in the same cycle. No event is lost across epochs.
- CTRL write coincident with events: the new enable takes effect from the next cycle.
- Live counters are never directly readable. MSB and LSB reads always come from the same snapshot.
- Reset mid-transaction: all state clears. If i_cs is still high after reset release, it counts as a new rising edge (cs_d=0), so one access occurs.

Optional Feature:
NTS_API_STATS_SATURATE_EN
- Defined: counters saturate at all-ones instead of wrapping. CTRL bit31 reads 1, as a capability flag, and is not writable.
- Undefined: counters wrap, and CTRL bit31 is an ordinary stored bit.

Decomposition:
- Package nts_api_stats_pkg:
  - address localparams (ADDR_NAME0, ADDR_NAME1, ADDR_VERSION, ADDR_CTRL, ADDR_SCRATCH, ADDR_SNAPSHOT, ADDR_CNT_BASE)
  - CTRL bit indices (CTRL_ENABLE_BIT, CTRL_CLEAR_BIT, CTRL_SATCAP_BIT)
  - NAME0/NAME1/VERSION constants
- Sub-module nts_event_counter: one COUNTER_WIDTH counter with inputs enable, event, snapshot, clear and outputs count and snapshot. It holds the saturate/wrap logic under the macro. The top-level module instantiates it NUM_COUNTERS times and contains the strobe, register file and read mux.

Test Plan:
- Read ID: read 0x00/0x01/0x02 → o_read_data 0x4e54532d / 0x53544154 / 0x302e3130, two cycles after i_cs rises.
- Single access: write SCRATCH=0xdeadbeef while holding i_cs high 50 cycles with i_write_data changing mid-hold → SCRATCH reads back 0xdeadbeef (first value only).
- Counting: CTRL=1, pulse i_events[2] 5 times, write SNAPSHOT, read 0x15 → 5, read 0x14 → 0; other counters read 0.
- Clear on snapshot with coincident event: CTRL=3, counter0=7, event on the SNAPSHOT write cycle → snapshot0 LSB=7; next snapshot with no events → 1.
- Wrap/saturate: force counter1 to all-ones via events with COUNTER_WIDTH=33, one more event → snapshot 0. With NTS_API_STATS_SATURATE_EN → snapshot MSB=1, LSB=0xffffffff, and CTRL bit31 reads 1.
- Reset mid-hold: assert i_areset during a held write of CTRL; release with i_cs high and i_we=1 → exactly one write occurs after release, and all counters and snapshots read 0.
